key_event: RTL and testbench
============================

Name: key_event

Overview:
- Consumes the single-bit debounced key level produced by the shell's debouncer.
- Converts it into one-cycle event pulses: press, release, long-press and auto-repeat.
- Sits between the debouncer and the front-panel command decoder, so downstream logic never edge-detects raw levels.
- One instance per panel key.

Parameters:
- hold_cycles, 50000000: cycles the key must stay held after the press pulse before long_pulse fires. Legal range is 2 or more.
- repeat_cycles, 10000000: period in cycles between repeat pulses once in the held state. Legal range is 2 or more.

Ports:
- clk  input  1: system clock; all logic is on the rising edge.
- reset  input  1: asynchronous, active-high reset.
- debounced_sig  input  1: debounced key level, synchronous to clk; 1 = pressed.
- key_level  output  1: registered copy of debounced_sig.
- press_pulse  output  1: one-cycle pulse on a key press.
- release_pulse  output  1: one-cycle pulse on a key release.
- long_pulse  output  1: one-cycle pulse when the long-press threshold is reached.
- repeat_pulse  output  1: one-cycle pulse for each auto-repeat tick.

Behaviour:
- Reset is asynchronous, active-high, on port reset. While reset is asserted:
  - all outputs are 0
  - state = IDLE
  - counter = 0
- Reset deassertion is synchronous to clk upstream; the block does no re-synchronisation.
- Counter width is $clog2(max(hold_cycles, repeat_cycles)) + 1. The counter never wraps.
- All outputs are registered. Each pulse is high for exactly one cycle. key_level lags debounced_sig by 1 cycle.
- At most one of the four pulses is high in any cycle.
- State machine, evaluated on each rising edge (S = debounced_sig):
  - IDLE:
    - S=1: press_pulse <= 1; counter <= 0; go to PRESSED.
    - Otherwise stay in IDLE.
  - PRESSED:
    - S=0: release_pulse <= 1; counter <= 0; go to IDLE.
    - S=1 and counter == hold_cycles-1: long_pulse <= 1; counter <= 0; go to HELD.
    - Otherwise counter <= counter+1.
  - HELD:
    - S=0: release_pulse <= 1; counter <= 0; go to IDLE.
    - S=1 and counter == repeat_cycles-1: repeat_pulse <= 1; counter <= 0.
    - Otherwise counter <= counter+1.
- Resulting latency:
  - press_pulse: 1 cycle after S rises.
  - long_pulse: hold_cycles cycles after press_pulse.
  - Each repeat_pulse: repeat_cycles cycles after the previous long_pulse or repeat_pulse.
  - release_pulse: 1 cycle after S falls.
- Boundary conditions:
  - Release and threshold on the same edge: release wins. No long_pulse or repeat_pulse is emitted, and the counter is cleared.
  - A one-cycle high on S gives press_pulse followed directly by release_pulse on consecutive cycles.
  - Reset asserted mid-hold forces IDLE immediately. No release_pulse is emitted.
  - If S is already 1 when reset deasserts, press_pulse fires on the first edge.
- Unused states in the state encoding recover to IDLE on the next edge.

Optional Feature:
- Macro: KEY_EVENT_REPEAT_EN.
- Defined:
  - HELD state and repeat_pulse behave as described above.
- Undefined:
  - The PRESSED threshold goes to a terminal HELD state that only waits for release; the counter is frozen at 0.
  - repeat_pulse is tied to 0.
  - The repeat_cycles parameter is accepted but ignored.
  - Counter width is sized from hold_cycles only.

Decomposition:
- Shared shell package/header holds:
  - the state encoding localparams: KE_IDLE=2'd0, KE_PRESSED=2'd1, KE_HELD=2'd2
  - the default hold/repeat cycle constants, so the shell top and testbenches use the same values.
- No sub-module: counter and FSM are one always-block pair.
- The shell top instantiates debouncer followed by key_event per key.

Test Plan (hold_cycles=8, repeat_cycles=4, KEY_EVENT_REPEAT_EN defined unless noted):
1. S rises at edge 10 and falls at edge 14 -> press_pulse at cycle 11; release_pulse at cycle 15; no long_pulse; key_level follows S with a 1-cycle lag.
2. S rises at edge 10 and is held -> press_pulse at 11; long_pulse at 19; repeat_pulse at 23, 27 and 31; release_pulse 1 cycle after the fall.
3. S falls on the same edge the counter reaches 7 in PRESSED -> release_pulse only; no long_pulse; state returns to IDLE.
4. Reset asserted asynchronously mid-cycle during HELD -> all outputs 0 immediately; no release_pulse; a subsequent press gives a fresh press_pulse and long_pulse 8 cycles later.
5. S single-cycle high at edge 5 -> press_pulse at 6 and release_pulse at 7; never two pulses in one cycle.
6. Build without KEY_EVENT_REPEAT_EN and hold S for 40 cycles -> long_pulse once at press+8; repeat_pulse stays 0; release_pulse on the fall.

Source files
------------

// File: rtl/key_event_pkg.sv
// Shared definitions for the key_event block: state encoding and default
// hold/repeat thresholds used by the shell top and by testbenches.
package key_event_pkg;

  typedef enum logic [1:0] {
    KE_IDLE    = 2'd0,
    KE_PRESSED = 2'd1,
    KE_HELD    = 2'd2
  } ke_state_t;

  localparam int KE_HOLD_CYCLES   = 50000000;
  localparam int KE_REPEAT_CYCLES = 10000000;

  function automatic int ke_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_event.sv
// Turns a debounced key level into one-cycle press/release/long/repeat pulses.
// Auto-repeat is built only when KEY_EVENT_REPEAT_EN is defined.
module key_event
  import key_event_pkg::*;
#(
  parameter int hold_cycles   = KE_HOLD_CYCLES,
  parameter int repeat_cycles = KE_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic debounced_sig,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

`ifdef KEY_EVENT_REPEAT_EN
  localparam int CW = $clog2(ke_max(hold_cycles, repeat_cycles)) + 1;
  localparam logic [CW-1:0] RPT_LAST = CW'(repeat_cycles - 1);
`else
  localparam int CW = $clog2(hold_cycles) + 1;
`endif
  localparam logic [CW-1:0] HOLD_LAST = CW'(hold_cycles - 1);

  // Thresholds below 2 would collide with the press/threshold edges.
  if (hold_cycles < 2) begin : g_bad_hold
    $error("key_event: hold_cycles must be at least 2");
  end
  if (repeat_cycles < 2) begin : g_bad_repeat
    $error("key_event: repeat_cycles must be at least 2");
  end

  ke_state_t       state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            press_nx, release_nx, long_nx, repeat_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= KE_IDLE;
      cnt           <= '0;
      key_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      key_level     <= debounced_sig;
      press_pulse   <= press_nx;
      release_pulse <= release_nx;
      long_pulse    <= long_nx;
      repeat_pulse  <= repeat_nx;
    end
  end

  // Release is tested before any threshold so it wins on a shared edge.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    long_nx    = 1'b0;
    repeat_nx  = 1'b0;
    case (state)
      KE_IDLE: begin
        if (debounced_sig) begin
          press_nx = 1'b1;
          cnt_nx   = '0;
          state_nx = KE_PRESSED;
        end
      end
      KE_PRESSED: begin
        if (!debounced_sig) begin
          release_nx = 1'b1;
          cnt_nx     = '0;
          state_nx   = KE_IDLE;
        end else if (cnt == HOLD_LAST) begin
          long_nx  = 1'b1;
          cnt_nx   = '0;
          state_nx = KE_HELD;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      KE_HELD: begin
        if (!debounced_sig) begin
          release_nx = 1'b1;
          cnt_nx     = '0;
          state_nx   = KE_IDLE;
        end else begin
`ifdef KEY_EVENT_REPEAT_EN
          if (cnt == RPT_LAST) begin
            repeat_nx = 1'b1;
            cnt_nx    = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
`else
          // Terminal state without auto-repeat: counter parked at zero.
          cnt_nx = '0;
`endif
        end
      end
      default: begin
        state_nx = KE_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event with hold_cycles=8, repeat_cycles=4.
// Each step compares {key_level, press, release, long, repeat} after an edge.
module tb_key_event;

  localparam int HOLD = 8;
  localparam int RPT  = 4;

  logic clk = 1'b0;
  logic reset;
  logic debounced_sig;
  logic key_level, press_pulse, release_pulse, long_pulse, repeat_pulse;

  int checks = 0;
  int errors = 0;

  key_event #(
    .hold_cycles   (HOLD),
    .repeat_cycles (RPT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .debounced_sig (debounced_sig),
    .key_level     (key_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {key_level, press_pulse, release_pulse, long_pulse, repeat_pulse};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
    checks++;
    assert ($onehot0(obs[3:0]) === 1'b1) else begin
      errors++;
      $error("FAIL %s_onehot: observed pulses %b expected at most one high", tag, obs[3:0]);
    end
  endtask

  task automatic tick(input string tag, input logic [4:0] exp);
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  task automatic ticks(input string tag, input logic [4:0] exp, input int n);
    for (int i = 0; i < n; i++) tick(tag, exp);
  endtask

  initial begin
    reset         = 1'b1;
    debounced_sig = 1'b0;
    #1;
    check("reset_state", 5'b00000);
    ticks("reset_held", 5'b00000, 2);
    reset = 1'b0;
    ticks("idle", 5'b00000, 2);

    // Short press: rise, held for 4 edges, fall.
    debounced_sig = 1'b1;
    tick("t1_press", 5'b11000);
    ticks("t1_hold", 5'b10000, 3);
    debounced_sig = 1'b0;
    tick("t1_release", 5'b00100);
    ticks("t1_idle", 5'b00000, 3);

    // Single-cycle high: press then release back to back.
    debounced_sig = 1'b1;
    tick("t5_press", 5'b11000);
    debounced_sig = 1'b0;
    tick("t5_release", 5'b00100);
    ticks("t5_idle", 5'b00000, 2);

    // Long hold: long at press+8, then repeats every 4 cycles (if built).
    debounced_sig = 1'b1;
    tick("t2_press", 5'b11000);
    ticks("t2_hold", 5'b10000, HOLD - 1);
    tick("t2_long", 5'b10010);
`ifdef KEY_EVENT_REPEAT_EN
    for (int r = 0; r < 3; r++) begin
      ticks("t2_gap", 5'b10000, RPT - 1);
      tick("t2_repeat", 5'b10001);
    end
    ticks("t2_tail", 5'b10000, 2);
`else
    ticks("t6_held_no_repeat", 5'b10000, 31);
`endif
    debounced_sig = 1'b0;
    tick("t2_release", 5'b00100);
    ticks("t2_idle", 5'b00000, 3);

    // Release lands on the same edge as the hold threshold.
    debounced_sig = 1'b1;
    tick("t3_press", 5'b11000);
    ticks("t3_hold", 5'b10000, HOLD - 1);
    debounced_sig = 1'b0;
    tick("t3_release", 5'b00100);
    ticks("t3_idle", 5'b00000, 6);

    // Fresh press after the race must count a full hold again.
    debounced_sig = 1'b1;
    tick("t3_repress", 5'b11000);
    ticks("t3_rehold", 5'b10000, HOLD - 1);
    tick("t3_relong", 5'b10010);
    ticks("t4_held", 5'b10000, 2);

    // Asynchronous reset mid-cycle while held; key stays down through it.
    #3;
    reset = 1'b1;
    #1;
    check("t4_reset_async", 5'b00000);
    tick("t4_reset_held", 5'b00000);
    reset = 1'b0;
    tick("t4_press_after_reset", 5'b11000);
    ticks("t4_hold", 5'b10000, HOLD - 1);
    tick("t4_long", 5'b10010);
    debounced_sig = 1'b0;
    tick("t4_release", 5'b00100);
    ticks("t4_idle", 5'b00000, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
